// File: rtl/tx_stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tx_stream_fifo
//  Purpose  : Transmit FIFO with a full 2**AW word RAM, occupancy count,
//             almost-full flag and a registered valid/ready output stage.
//             Optional synchronous FLUSH enabled by TX_STREAM_FIFO_FLUSH_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tx_stream_fifo #(
    parameter int WIDTH     = 8,
    parameter int AW        = 10,
    parameter int AFULL_LVL = 1020
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] IN,
    input  logic             WE,
    output logic             FULL,
    output logic             AFULL,
    output logic             EMPTY,
    output logic [AW:0]      COUNT,
    output logic [WIDTH-1:0] OUT,
    output logic             OE,
`ifdef TX_STREAM_FIFO_FLUSH_EN
    input  logic             FLUSH,
`endif
    input  logic             OR
);

    localparam int        c_DEPTH = 1 << AW;
    localparam logic [AW:0] c_AFULL = (AW+1)'(AFULL_LVL);
    localparam logic [AW:0] c_ONE   = (AW+1)'(1);

    logic [WIDTH-1:0] r_mem [c_DEPTH];
    logic [AW:0]      r_wp;
    logic [AW:0]      r_rp;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_out;
    logic             r_oe;

    logic             w_full;
    logic             w_empty;
    logic             w_flush;
    logic             w_wr;
    logic             w_load;
    logic [AW:0]      w_wp_nxt;
    logic [AW:0]      w_rp_nxt;
    logic             w_oe_nxt;

`ifdef TX_STREAM_FIFO_FLUSH_EN
    assign w_flush = FLUSH;
`else
    assign w_flush = 1'b0;
`endif

    // Status comes from registered pointers only, never from this cycle's inputs.
    assign w_empty = (r_wp == r_rp);
    assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);

    assign w_wr   = WE && !w_full;
    assign w_load = !w_flush && !w_empty && (!r_oe || OR);

    always_comb begin
        w_wp_nxt = w_wr ? (r_wp + c_ONE) : r_wp;
        w_rp_nxt = r_rp;
        w_oe_nxt = r_oe;
        if (w_flush) begin
            // Old write pointer: a same-cycle write survives as the only word.
            w_rp_nxt = r_wp;
            w_oe_nxt = 1'b0;
        end else if (w_load) begin
            w_rp_nxt = r_rp + c_ONE;
            w_oe_nxt = 1'b1;
        end else if (r_oe && OR) begin
            w_oe_nxt = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_wr) begin
            r_mem[r_wp[AW-1:0]] <= IN;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_oe    <= 1'b0;
            r_out   <= '0;
        end else begin
            r_wp    <= w_wp_nxt;
            r_rp    <= w_rp_nxt;
            r_count <= w_wp_nxt - w_rp_nxt;
            r_oe    <= w_oe_nxt;
            if (w_load) begin
                r_out <= r_mem[r_rp[AW-1:0]];
            end
        end
    end

    assign FULL  = w_full;
    assign EMPTY = w_empty;
    assign AFULL = (r_count >= c_AFULL);
    assign COUNT = r_count;
    assign OUT   = r_out;
    assign OE    = r_oe;

endmodule
`default_nettype wire

// File: tb/tb_tx_stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tx_stream_fifo
//  Purpose  : Self-checking bench for tx_stream_fifo against a queue model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tx_stream_fifo;

    localparam int WIDTH     = 8;
    localparam int AW        = 4;
    localparam int AFULL_LVL = 14;
    localparam int DEPTH     = 1 << AW;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic [WIDTH-1:0] IN = '0;
    logic             WE = 1'b0;
    logic             OR = 1'b0;
    logic             FLUSH = 1'b0;
    logic             FULL, AFULL, EMPTY, OE;
    logic [AW:0]      COUNT;
    logic [WIDTH-1:0] OUT;

    int nchecks = 0;
    int nerr    = 0;

    tx_stream_fifo #(.WIDTH(WIDTH), .AW(AW), .AFULL_LVL(AFULL_LVL)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .IN    (IN),
        .WE    (WE),
        .FULL  (FULL),
        .AFULL (AFULL),
        .EMPTY (EMPTY),
        .COUNT (COUNT),
        .OUT   (OUT),
        .OE    (OE),
`ifdef TX_STREAM_FIFO_FLUSH_EN
        .FLUSH (FLUSH),
`endif
        .OR    (OR)
    );

    always #5 CLK = ~CLK;

    // Reference: RAM as a queue of words plus an output register.
    logic [WIDTH-1:0] m_q[$];
    logic             m_oe  = 1'b0;
    logic [WIDTH-1:0] m_out = '0;

    always @(posedge CLK or negedge RST_N) begin
        bit pre_full, pre_empty, fl;
        if (!RST_N) begin
            m_q.delete();
            m_oe  = 1'b0;
            m_out = '0;
        end else begin
            pre_full  = (m_q.size() == DEPTH);
            pre_empty = (m_q.size() == 0);
`ifdef TX_STREAM_FIFO_FLUSH_EN
            fl = FLUSH;
`else
            fl = 1'b0;
`endif
            if (fl) begin
                m_q.delete();
                m_oe = 1'b0;
            end else if (!pre_empty && (!m_oe || OR)) begin
                m_out = m_q.pop_front();
                m_oe  = 1'b1;
            end else if (m_oe && OR) begin
                m_oe = 1'b0;
            end
            if (WE && !pre_full) m_q.push_back(IN);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        chk("oe",    32'(OE),    32'(m_oe));
        chk("out",   32'(OUT),   32'(m_out));
        chk("count", 32'(COUNT), 32'(m_q.size()));
        chk("empty", 32'(EMPTY), 32'(m_q.size() == 0));
        chk("full",  32'(FULL),  32'(m_q.size() == DEPTH));
        chk("afull", 32'(AFULL), 32'(m_q.size() >= AFULL_LVL));
    end

    // Apply inputs for one edge; return 1 time unit after it.
    task automatic cyc(input logic we, input logic [WIDTH-1:0] d, input logic rdy);
        WE = we;
        IN = d;
        OR = rdy;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int k;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_oe",    32'(OE),    32'd0);
        chk("rst_empty", 32'(EMPTY), 32'd1);
        chk("rst_full",  32'(FULL),  32'd0);
        chk("rst_count", 32'(COUNT), 32'd0);
        chk("rst_out",   32'(OUT),   32'd0);
        RST_N = 1'b1;

        // Latency of a single word.
        cyc(1'b1, 8'hA5, 1'b1);
        chk("lat_oe0", 32'(OE), 32'd0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("lat_oe1", 32'(OE), 32'd1);
        chk("lat_out", 32'(OUT), 32'hA5);
        cyc(1'b0, 8'h00, 1'b1);
        chk("lat_oe2", 32'(OE), 32'd0);
        chk("lat_cnt", 32'(COUNT), 32'd0);

        // Backpressure holds the head word.
        cyc(1'b1, 8'h11, 1'b0);
        cyc(1'b1, 8'h22, 1'b0);
        cyc(1'b1, 8'h33, 1'b0);
        repeat (10) cyc(1'b0, 8'h00, 1'b0);
        chk("bp_hold", 32'(OUT), 32'h11);
        chk("bp_oe",   32'(OE),  32'd1);
        chk("bp_cnt",  32'(COUNT), 32'd2);
        cyc(1'b0, 8'h00, 1'b1);
        chk("bp_w2", 32'(OUT), 32'h22);
        cyc(1'b0, 8'h00, 1'b1);
        chk("bp_w3", 32'(OUT), 32'h33);
        cyc(1'b0, 8'h00, 1'b1);
        chk("bp_end", 32'(OE), 32'd0);

        // Fill: 16 in RAM, 17th in OUT, 18th dropped.
        for (int i = 0; i < 18; i++) cyc(1'b1, 8'(8'h41 + i), 1'b0);
        chk("fill_full",  32'(FULL),  32'd1);
        chk("fill_afull", 32'(AFULL), 32'd1);
        chk("fill_cnt",   32'(COUNT), 32'd16);
        chk("fill_out",   32'(OUT),   32'h41);
        k = 0;
        for (int i = 0; i < 20; i++) begin
            if (OE) begin
                chk("drain_word", 32'(OUT), 32'(8'h41 + k));
                k++;
            end
            cyc(1'b0, 8'h00, 1'b1);
        end
        chk("drain_total", 32'(k), 32'd17);

        // Streaming across pointer wrap.
        for (int i = 0; i < 100; i++) cyc(1'b1, 8'(i * 7 + 3), 1'b1);
        repeat (4) cyc(1'b0, 8'h00, 1'b1);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
`ifdef TX_STREAM_FIFO_FLUSH_EN
            FLUSH = ($urandom_range(0, 63) == 0);
`endif
            cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) == 0));
        end
        FLUSH = 1'b0;
        repeat (20) cyc(1'b0, 8'h00, 1'b1);

        // Async reset with COUNT=5, OE=1.
        for (int i = 0; i < 6; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0);
        chk("pre_rst_cnt", 32'(COUNT), 32'd5);
        chk("pre_rst_oe",  32'(OE),    32'd1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("arst_oe",    32'(OE),    32'd0);
        chk("arst_cnt",   32'(COUNT), 32'd0);
        chk("arst_empty", 32'(EMPTY), 32'd1);
        WE = 1'b0;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;

`ifdef TX_STREAM_FIFO_FLUSH_EN
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h90 + i), 1'b0);
        FLUSH = 1'b1;
        cyc(1'b1, 8'h77, 1'b0);
        FLUSH = 1'b0;
        chk("flush_cnt", 32'(COUNT), 32'd1);
        chk("flush_oe",  32'(OE),    32'd0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("flush_oe1", 32'(OE),  32'd1);
        chk("flush_out", 32'(OUT), 32'h77);
        cyc(1'b0, 8'h00, 1'b1);
`endif

        repeat (3) cyc(1'b0, 8'h00, 1'b0);
        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
`default_nettype wire
